// File: rtl/flag_pkg.sv
// flag_pkg: shared ALU opcode, NZCV flag struct and partial-write helpers for the flag producer.
package flag_pkg;
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_t;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;
  localparam flags_t FLAGS_CLR = '0;
  function automatic flags_t merge_flags(input flags_t cur, input flags_t nxt, input logic [1:0] fw);
    return '{
      n: fw[FLAGW_NZ] ? nxt.n : cur.n,
      z: fw[FLAGW_NZ] ? nxt.z : cur.z,
      c: fw[FLAGW_CV] ? nxt.c : cur.c,
      v: fw[FLAGW_CV] ? nxt.v : cur.v
    };
  endfunction
endpackage

// File: rtl/flag_alu.sv
// flag_alu: combinational execute-stage ALU producing Result and candidate NZCV.
module flag_alu
  import flag_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t            i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_result,
  output flags_t             o_flags
);
  localparam int M = WIDTH - 1;
  logic             w_sub;
  logic             w_arith;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  assign w_sub   = (i_op == ALU_SUB);
  assign w_arith = (i_op == ALU_ADD) | w_sub;
  // SUB is A + ~B + 1, so carry out means "no borrow"
  assign w_b   = w_sub ? ~i_b : i_b;
  assign w_sum = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_sub};
  always_comb begin
    o_result = w_arith ? w_sum[M:0] : (i_op == ALU_AND) ? (i_a & i_b) : (i_a | i_b);
    o_flags.n = o_result[M];
    o_flags.z = (o_result == '0);
    o_flags.c = w_arith & w_sum[WIDTH];
    o_flags.v = w_arith & (i_a[M] == w_b[M]) & (o_result[M] != i_a[M]);
  end
endmodule

// File: rtl/flag_gen_reg.sv
// flag_gen_reg: architectural NZCV register with partial writes, shadow save/restore and update pulse.
// Optional FLAG_FORWARD_EN adds FlagsFwd, the value Flags will hold after the next edge.
module flag_gen_reg
  import flag_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             CondEx,
  input  logic [1:0]       FlagW,
  input  logic [1:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags,
  output logic [3:0]       ShadowFlags,
  input  logic             Save,
  input  logic             Restore,
`ifdef FLAG_FORWARD_EN
  output logic [3:0]       FlagsFwd,
`endif
  output logic             FlagsUpdated
);
  flags_t r_flags;
  flags_t r_shadow;
  logic   r_updated;
  flags_t w_alu_flags;
  flags_t w_next;
  logic   w_we;
  flag_alu #(.WIDTH(WIDTH)) u_alu (
    .i_op     (alu_op_t'(ALUControl)),
    .i_a      (SrcA),
    .i_b      (SrcB),
    .o_result (Result),
    .o_flags  (w_alu_flags)
  );
  assign w_we = Valid & ~Stall & ~Flush & CondEx;
  // Restore overrides the ALU write; reset overrides everything
  assign w_next = reset   ? FLAGS_CLR :
                  Stall   ? r_flags   :
                  Restore ? r_shadow  :
                  w_we    ? merge_flags(r_flags, w_alu_flags, FlagW) : r_flags;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags   <= FLAGS_CLR;
      r_shadow  <= FLAGS_CLR;
      r_updated <= 1'b0;
    end else if (!Stall) begin
      r_flags   <= w_next;
      r_shadow  <= Save ? r_flags : r_shadow;
      r_updated <= ~Restore & w_we & (|FlagW);
    end
  end
  assign Flags        = r_flags;
  assign ShadowFlags  = r_shadow;
  assign FlagsUpdated = r_updated;
`ifdef FLAG_FORWARD_EN
  assign FlagsFwd = w_next;
`endif
endmodule

// File: tb/tb_flag_gen_reg.sv
// tb_flag_gen_reg: directed scoreboard bench for flag_gen_reg (FlagsFwd checked when FLAG_FORWARD_EN is defined).
module tb_flag_gen_reg;
  localparam int W = 32;
  localparam int M = W - 1;
  logic clk = 1'b0;
  logic reset = 1'b1, Valid = 1'b0, Stall = 1'b0, Flush = 1'b0, CondEx = 1'b0, Save = 1'b0, Restore = 1'b0;
  logic [1:0] FlagW = 2'b00, ALUControl = 2'b00;
  logic [W-1:0] SrcA = '0, SrcB = '0, Result;
  logic [3:0] Flags, ShadowFlags;
  logic FlagsUpdated;
`ifdef FLAG_FORWARD_EN
  logic [3:0] FlagsFwd;
`endif
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [3:0] f;
    logic [3:0] s;
    logic       u;
  } exp_t;
  exp_t q[$];
  logic [3:0] m_f = 4'b0000, m_s = 4'b0000;
  logic m_u = 1'b0;

  flag_gen_reg #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Valid(Valid), .Stall(Stall), .Flush(Flush), .CondEx(CondEx),
    .FlagW(FlagW), .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .Result(Result),
    .Flags(Flags), .ShadowFlags(ShadowFlags), .Save(Save), .Restore(Restore),
`ifdef FLAG_FORWARD_EN
    .FlagsFwd(FlagsFwd),
`endif
    .FlagsUpdated(FlagsUpdated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic alu_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic [3:0] nzcv);
    logic [W:0] s;
    logic c, v;
    case (op)
      2'b00: s = {1'b0, a} + {1'b0, b};
      2'b01: s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      2'b10: s = {1'b0, a & b};
      default: s = {1'b0, a | b};
    endcase
    r = s[W-1:0];
    c = (op == 2'b00 || op == 2'b01) ? s[W] : 1'b0;
    v = (op == 2'b00) ? ((a[M] == b[M]) && (r[M] != a[M])) :
        (op == 2'b01) ? ((a[M] != b[M]) && (r[M] != a[M])) : 1'b0;
    nzcv = {r[M], r == '0, c, v};
  endtask

  task automatic step(input string tag, input logic v, input logic st, input logic fl, input logic ce,
                      input logic [1:0] fw, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sv, input logic rs, input logic rst);
    logic [W-1:0] r;
    logic [3:0] nz, nf, ns;
    logic we, nu;
    exp_t e;
    reset = rst; Valid = v; Stall = st; Flush = fl; CondEx = ce; FlagW = fw; ALUControl = op;
    SrcA = a; SrcB = b; Save = sv; Restore = rs;
    #1;
    alu_model(op, a, b, r, nz);
    if (v) chk({tag, "_result"}, Result, r);
    we = v && !st && !fl && ce;
    if (rst) begin
      nf = 4'b0000; ns = 4'b0000; nu = 1'b0;
    end else if (st) begin
      nf = m_f; ns = m_s; nu = m_u;
    end else begin
      ns = sv ? m_f : m_s;
      nf = m_f;
      if (rs) nf = m_s;
      else if (we) begin
        if (fw[1]) nf[3:2] = nz[3:2];
        if (fw[0]) nf[1:0] = nz[1:0];
      end
      nu = !rs && we && (fw != 2'b00);
    end
`ifdef FLAG_FORWARD_EN
    chk({tag, "_fwd"}, FlagsFwd, nf);
`endif
    q.push_back('{f: nf, s: ns, u: nu});
    m_f = nf; m_s = ns; m_u = nu;
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, "_flags"}, Flags, e.f);
    chk({tag, "_shadow"}, ShadowFlags, e.s);
    chk({tag, "_upd"}, FlagsUpdated, e.u);
  endtask

  initial begin
    step("reset", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    chk("reset_flags_const", Flags, 4'b0000);
    step("add_ovf", 1, 0, 0, 1, 2'b11, 2'b00, 32'h7FFF_FFFF, 32'h1, 0, 0, 0);
    chk("add_ovf_const", Flags, 4'b1001);
    chk("add_ovf_pulse", FlagsUpdated, 1'b1);
    step("idle", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    chk("pulse_one_cycle", FlagsUpdated, 1'b0);
    step("sub_eq", 1, 0, 0, 1, 2'b11, 2'b01, 32'd5, 32'd5, 0, 0, 0);
    chk("sub_eq_const", Flags, 4'b0110);
    step("and_nz", 1, 0, 0, 1, 2'b10, 2'b10, 32'h0, 32'hF, 0, 0, 0);
    chk("and_nz_const", Flags, 4'b0110);
    step("condfail", 1, 0, 0, 0, 2'b11, 2'b00, 32'hFFFF_FFFF, 32'h1, 0, 0, 0);
    step("flush", 1, 0, 1, 1, 2'b11, 2'b00, 32'hFFFF_FFFF, 32'h1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall", 1, 1, 0, 1, 2'b11, 2'b00, 32'hFFFF_FFFF, 32'h1, 1, i == 1, 0);
    chk("stall_const", Flags, 4'b0110);
    chk("stall_noupd", FlagsUpdated, 1'b0);
    step("set1001", 1, 0, 0, 1, 2'b11, 2'b00, 32'h7FFF_FFFF, 32'h1, 0, 0, 0);
    step("save", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    chk("save_const", ShadowFlags, 4'b1001);
    step("sub33", 1, 0, 0, 1, 2'b11, 2'b01, 32'd3, 32'd3, 0, 0, 0);
    step("restore_wr", 1, 0, 0, 1, 2'b11, 2'b00, 32'hFFFF_FFFF, 32'h1, 0, 1, 0);
    chk("restore_const", Flags, 4'b1001);
    chk("restore_noupd", FlagsUpdated, 1'b0);
    step("sub33b", 1, 0, 0, 1, 2'b11, 2'b01, 32'd3, 32'd3, 0, 0, 0);
    step("swap", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0);
    chk("swap_flags_const", Flags, 4'b1001);
    chk("swap_shadow_const", ShadowFlags, 4'b0110);
    step("mid_reset", 1, 0, 0, 1, 2'b11, 2'b01, 32'd1, 32'd2, 1, 0, 1);
    chk("mid_reset_const", Flags | ShadowFlags, 4'b0000);
    step("orr_n", 1, 0, 0, 1, 2'b11, 2'b11, 32'h8000_0000, 32'h0, 0, 0, 0);
    step("add_cv_only", 1, 0, 0, 1, 2'b01, 2'b00, 32'hFFFF_FFFF, 32'h1, 0, 0, 0);
    chk("add_cv_only_const", Flags, 4'b1010);
    step("sub_borrow", 1, 0, 0, 1, 2'b11, 2'b01, 32'd3, 32'd5, 0, 0, 0);
    step("sub_ovf", 1, 0, 0, 1, 2'b11, 2'b01, 32'h8000_0000, 32'h1, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      step("rand", $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) != 0, 2'($urandom), 2'($urandom), $urandom, $urandom,
           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/flag_gen_reg.md
Name: flag_gen_reg

Overview:
- Producer end of the condition-flag interface: computes NZCV from an execute-stage ALU operation and holds it in the architectural flag register.
- The registered Flags[3:0] output, ordered {N,Z,C,V}, is the value the condition checker consumes.
- Applies ARM-style partial flag writes gated by the instruction's condition outcome.
- Provides a shadow copy for exception save/restore.

Parameters:
- WIDTH, 32, datapath width of SrcA/SrcB/Result.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Valid  in  1  execute-stage instruction present this cycle.
- Stall  in  1  pipeline stall; freezes all state updates except reset.
- Flush  in  1  kills the instruction presented this cycle.
- CondEx  in  1  condition check passed for this instruction.
- FlagW  in  2  bit1: write N,Z; bit0: write C,V.
- ALUControl  in  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- SrcA  in  WIDTH  operand A.
- SrcB  in  WIDTH  operand B.
- Result  out  WIDTH  combinational ALU result.
- Flags  out  4  registered architectural flags {N,Z,C,V}.
- ShadowFlags  out  4  registered saved copy.
- Save  in  1  copy Flags into the shadow register.
- Restore  in  1  load the shadow register into Flags.
- FlagsUpdated  out  1  registered pulse: Flags changed by an ALU write last edge.

Behaviour:
- Reset: Flags=0000, ShadowFlags=0000, FlagsUpdated=0. Flags return to 0000 on the edge reset is sampled, including mid-operation.
- Arithmetic (combinational):
  - ADD: {cout,Result}=SrcA+SrcB, computed at WIDTH+1 bits.
  - SUB: {cout,Result}=SrcA+~SrcB+1, so C=1 means no borrow.
  - AND/ORR: bitwise; cout=0.
- Next-flag values:
  - N=Result[WIDTH-1].
  - Z=(Result==0).
  - C=cout for ADD/SUB, 0 for logic ops.
  - V: ADD is (A[msb]==B[msb])&(R[msb]!=A[msb]); SUB is (A[msb]!=B[msb])&(R[msb]!=A[msb]); logic ops give 0.
- Write qualifier: we = Valid & ~Stall & ~Flush & CondEx.
- Update, latency 1 cycle:
  - At the edge, if we & FlagW[1]: N,Z take the next values.
  - If we & FlagW[0]: C,V take the next values.
  - Unselected bits hold.
- FlagsUpdated is registered: it equals 1 for the cycle after any edge where we & (FlagW!=00), else 0.
- Shadow:
  - Save & ~Stall: ShadowFlags <= Flags, using the pre-update value.
  - Restore & ~Stall: Flags <= ShadowFlags; the ALU write is suppressed that edge and FlagsUpdated=0.
- Priority: reset > Restore > ALU write. Save combines with any of these; the shadow always captures the old Flags.
- Save & Restore in the same cycle: the values swap.
- Stall=1: Flags, ShadowFlags and FlagsUpdated all hold; FlagsUpdated does not re-pulse.
- Flush=1 or CondEx=0: no flag change; Result is still driven.
- Valid=0: Result is don't-care; no updates occur.

Optional Feature:
- FLAG_FORWARD_EN defined:
  - Adds output FlagsFwd[3:0].
  - FlagsFwd equals the value Flags will hold after the next edge: merged partial write, or shadow on Restore, or 0000 on reset.
  - Lets a condition check in the same cycle see in-flight flags.
- Not defined: the port is absent; consumers use Flags only.

Decomposition:
- Shared package flag_pkg:
  - alu_op_t enum (ADD/SUB/AND/ORR).
  - flags_t packed struct {n,z,c,v}.
  - FLAGW_NZ / FLAGW_CV bit-index constants.
- One sub-module, flag_alu: combinational Result/N/Z/C/V computation.
- flag_gen_reg keeps the registers, qualifiers and shadow logic.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+0x00000001, FlagW=11, CondEx=1 -> next cycle Flags=1001, FlagsUpdated=1 one cycle.
- SUB 5-5, FlagW=11 -> Flags=0110. Then AND 0x0+0xF, FlagW=10 -> Flags=0110 (C,V held).
- ADD 0xFFFFFFFF+1, FlagW=11, CondEx=0 -> Flags unchanged. Repeat with Flush=1 -> unchanged. Repeat with Stall=1 for 3 cycles -> unchanged, FlagsUpdated=0.
- Flags=1001; Save -> Shadow=1001. Then SUB 3-3 -> Flags=0110. Restore asserted with a concurrent ALU write -> Flags=1001, FlagsUpdated=0.
- Flags=0110, Shadow=1001; Save & Restore same cycle -> Flags=1001, Shadow=0110. Reset asserted mid-sequence -> both 0000 next edge.
- With FLAG_FORWARD_EN: ADD 0xFFFFFFFF+1, FlagW=01 from Flags=1000 -> FlagsFwd=1010 same cycle, Flags=1010 next cycle.
